iterative_normalizer: RTL and testbench
=======================================

ITERATIVE_NORMALIZER -- requirements
Module: iterative_normalizer

Interface
REQ-001: The block SHALL have parameter BIT_WIDTH, default 32, operand width; power of two, >= 4.
REQ-002: The block SHALL have parameter GATE_DELAY, default 50, optional delay applied to combinational gate instances.
REQ-003: The block SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: reset  input  1  synchronous, active-high reset.
REQ-006: inValid  input  1  operand on `in` is valid.
REQ-007: inReady  output  1  block can accept an operand this cycle.
REQ-008: in  input  BIT_WIDTH  operand to normalize.
REQ-009: outValid  output  1  result on out/shiftAmt/isZero is valid.
REQ-010: outReady  input  1  consumer accepts result this cycle.
REQ-011: out  output  BIT_WIDTH  operand shifted left until MSB is 1; 0 for zero operand.
REQ-012: shiftAmt  output  $clog2(BIT_WIDTH)  leading-zero count, i.e. left-shift amount applied; directly usable as a BarrelShifter shift amount.
REQ-013: isZero  output  1  operand was all zeros.

Function
REQ-014: Purpose: compute the left-shift amount that normalizes an operand, i.e. the inverse of a left barrel shift.
REQ-015: State machine SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-016: inReady SHALL be 1 only in IDLE; outValid SHALL be 1 only in DONE.
REQ-017: IDLE: on inValid=1, load working register <= in, count <= 0, stage <= $clog2(BIT_WIDTH)-1, zero flag <= (in==0); go to SHIFT. Otherwise stay IDLE.
REQ-018: SHIFT: one stage per cycle, k = stage; if the top 2^k bits of the working register are all 0, shift it left by 2^k (zero fill) and set count bit k; else leave both unchanged.
REQ-019: SHIFT: after stage 0 is processed, go to DONE; otherwise decrement stage.
REQ-020: Latency: outValid SHALL rise exactly $clog2(BIT_WIDTH) cycles after the accept edge (5 for BIT_WIDTH=32), independent of operand value.
REQ-021: DONE: out = working register, shiftAmt = count, isZero = zero flag; held stable while outReady=0.
REQ-022: DONE with outReady=1: result consumed, go to IDLE; a new operand is NOT accepted in that same cycle (inReady=0 in DONE).
REQ-023: Zero operand: iterations still run (constant latency); in DONE, out SHALL be 0, shiftAmt SHALL be forced 0, isZero=1.
REQ-024: Operand with MSB already 1: out=in, shiftAmt=0, isZero=0.
REQ-025: inValid changes while not in IDLE SHALL be ignored; `in` is sampled only on the accept edge.
REQ-026: out, shiftAmt, isZero SHALL be 0 whenever outValid=0.

Reset
REQ-027: reset=1 at a clock edge SHALL force state IDLE, working register, count, stage and zero flag to 0, in any state.
REQ-028: After reset: inReady=1, outValid=0, out=0, shiftAmt=0, isZero=0.
REQ-029: Reset during SHIFT or DONE SHALL abort the operation with no result produced; reset has priority over all transitions.

Verification (BIT_WIDTH=32)
REQ-030: in=0x00000001 accepted -> 5 cycles later outValid=1, out=0x80000000, shiftAmt=31, isZero=0.
REQ-031: in=0x80000000 -> out=0x80000000, shiftAmt=0, isZero=0, latency still 5.
REQ-032: in=0x00000000 -> out=0, shiftAmt=0, isZero=1.
REQ-033: in=0x00F00000, outReady=0 for 3 cycles after outValid -> out=0xF0000000, shiftAmt=8 held stable, inReady=0 throughout; returns to IDLE the cycle after outReady=1.
REQ-034: reset=1 in 3rd SHIFT cycle -> next cycle IDLE, inReady=1, outValid=0; then in=0x00010000 -> out=0x80000000, shiftAmt=15.
REQ-035: Randomized back-to-back operands with random outReady -> out == in << shiftAmt, out[31]=1 for nonzero in, shiftAmt == leading-zero count of in.

Source files
------------

// File: rtl/iterative_normalizer.sv
// Iterative normalizer: finds the left shift that puts the operand's MSB at the top
// (leading-zero count), one binary-search stage per cycle, constant latency.
module iterative_normalizer #(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned GATE_DELAY = 50
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic [BIT_WIDTH-1:0]         in,
  output logic                         outValid,
  input  logic                         outReady,
  output logic [BIT_WIDTH-1:0]         out,
  output logic [$clog2(BIT_WIDTH)-1:0] shiftAmt,
  output logic                         isZero
);

  localparam int unsigned CntW = $clog2(BIT_WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state_q, state_d;
  logic [BIT_WIDTH-1:0] work_q, work_d;
  logic [CntW-1:0]      count_q, count_d;
  logic [CntW-1:0]      stage_q, stage_d;
  logic                 zero_q, zero_d;

  // Stage k examines the top 2^k bits; step is that shift distance.
  logic [CntW-1:0]      step;
  logic [BIT_WIDTH-1:0] top_mask;
  logic [BIT_WIDTH-1:0] all_ones;

  // Delay parameter only matters for gate-level models; nothing to apply in RTL.
  logic unused_gate_delay;
  assign unused_gate_delay = (GATE_DELAY != 0);

  // State and datapath registers, synchronous reset has priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      work_q  <= '0;
      count_q <= '0;
      stage_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      stage_q <= stage_d;
      zero_q  <= zero_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    count_d  = count_q;
    stage_d  = stage_q;
    zero_d   = zero_q;
    all_ones = '1;
    step     = CntW'(1) << stage_q;
    top_mask = ~(all_ones >> step);

    unique case (state_q)
      StIdle: begin
        if (inValid) begin
          work_d  = in;
          count_d = '0;
          stage_d = CntW'(CntW - 1);
          zero_d  = (in == '0);
          state_d = StShift;
        end
      end
      StShift: begin
        if ((work_q & top_mask) == '0) begin
          work_d  = work_q << step;
          count_d = count_q | (CntW'(1) << stage_q);
        end
        if (stage_q == '0) begin
          state_d = StDone;
        end else begin
          stage_d = stage_q - CntW'(1);
        end
      end
      StDone: begin
        if (outReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake and result outputs; results read as zero outside DONE.
  always_comb begin
    inReady  = (state_q == StIdle);
    outValid = (state_q == StDone);
    out      = outValid ? work_q : '0;
    // A zero operand still runs every stage, which would leave count all ones.
    shiftAmt = (outValid && !zero_q) ? count_q : '0;
    isZero   = outValid && zero_q;
  end

endmodule

// File: tb/tb_iterative_normalizer.sv
// Directed + randomized bench for iterative_normalizer with a result scoreboard.
module tb_iterative_normalizer;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic [W-1:0]  din;
  logic          outValid;
  logic          outReady;
  logic [W-1:0]  dout;
  logic [4:0]    shiftAmt;
  logic          isZero;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [W-1:0] out;
    logic [4:0]   sh;
    logic         zero;
  } exp_t;

  exp_t sb[$];

  iterative_normalizer #(.BIT_WIDTH(W), .GATE_DELAY(50)) dut (
    .clk      (clk),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .in       (din),
    .outValid (outValid),
    .outReady (outReady),
    .out      (dout),
    .shiftAmt (shiftAmt),
    .isZero   (isZero)
  );

  always #5 clk = ~clk;

  function automatic int lzc(input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) begin
      if (v[i]) return W - 1 - i;
    end
    return W;
  endfunction

  function automatic exp_t model(input logic [W-1:0] v);
    exp_t e;
    int   n;
    n = lzc(v);
    if (v == '0) begin
      e.out = '0; e.sh = '0; e.zero = 1'b1;
    end else begin
      e.out = v << n; e.sh = 5'(n); e.zero = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".inReady"}, W'(inReady), W'(1));
    check({tag, ".outValid"}, W'(outValid), W'(0));
    check({tag, ".out"}, dout, '0);
    check({tag, ".shiftAmt"}, W'(shiftAmt), W'(0));
    check({tag, ".isZero"}, W'(isZero), W'(0));
  endtask

  // Accept one operand, check constant latency, hold for 'hold' cycles, then consume.
  task automatic run(input logic [W-1:0] v, input int hold, input string tag);
    exp_t e;
    int   n;
    sb.push_back(model(v));
    @(negedge clk);
    n = 0;
    while (!inReady && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".accept_ready"}, W'(inReady), W'(1));
    inValid = 1'b1;
    din     = v;
    @(posedge clk);
    #1;
    // Keep inValid high with junk data while busy; it must be ignored.
    din = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!outValid && n < 20);
    inValid = 1'b0;
    check({tag, ".latency"}, W'(n - 1), W'(5));
    e = sb.pop_front();
    for (int h = 0; h <= hold; h++) begin
      check({tag, ".out"}, dout, e.out);
      check({tag, ".shiftAmt"}, W'(shiftAmt), W'(e.sh));
      check({tag, ".isZero"}, W'(isZero), W'(e.zero));
      check({tag, ".inReady_busy"}, W'(inReady), W'(0));
      check({tag, ".outValid"}, W'(outValid), W'(1));
      if (!isZero) begin
        check({tag, ".msb"}, W'(dout[W-1]), W'(1));
        check({tag, ".in_shifted"}, v << shiftAmt, dout);
      end
      if (h < hold) @(negedge clk);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    check_idle({tag, ".after"});
  endtask

  initial begin
    logic [W-1:0] rv;
    reset    = 1'b1;
    inValid  = 1'b0;
    din      = '0;
    outReady = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("reset");

    run(32'h0000_0001, 0, "one");
    run(32'h8000_0000, 0, "msb");
    run(32'h0000_0000, 0, "zero");
    run(32'h00F0_0000, 3, "hold");

    // Abort during the third SHIFT cycle: no result may appear.
    @(negedge clk);
    inValid = 1'b1;
    din     = 32'h0000_1234;
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_idle("abort");
    repeat (6) begin
      @(negedge clk);
      check("abort.no_result", W'(outValid), W'(0));
    end
    run(32'h0001_0000, 0, "post_abort");

    for (int i = 0; i < 24; i++) begin
      rv = $urandom;
      rv = rv >> $urandom_range(0, 32);
      run(rv, $urandom_range(0, 3), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
